// File: rtl/mfp_ahb_gpio_irq.sv
// AHB-Lite GPIO slave: set/clear/toggle outputs, synchronised inputs with edge-flag W1C status and level IRQ.
// Latency: reads return one edge after the address phase; writes commit on the edge ending the data phase.
// Backpressure: none, every transfer completes with zero wait states.
module mfp_ahb_gpio_irq #(
  parameter int N_IN        = 22,
  parameter int N_OUT       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [4:0]       HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HSEL,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  input  logic [N_IN-1:0]  GPIO_IN,
  output logic [N_OUT-1:0] GPIO_OUT,
  output logic             IRQ
);

  localparam logic [2:0] A_OUT     = 3'd0;
  localparam logic [2:0] A_OUT_SET = 3'd1;
  localparam logic [2:0] A_OUT_CLR = 3'd2;
  localparam logic [2:0] A_OUT_TGL = 3'd3;
  localparam logic [2:0] A_IN      = 3'd4;
  localparam logic [2:0] A_RISE_EN = 3'd5;
  localparam logic [2:0] A_FALL_EN = 3'd6;
  localparam logic [2:0] A_STATUS  = 3'd7;

  logic            acc;
  logic            wr_q;
  logic [2:0]      addr_q;
  logic [N_IN-1:0] sync_ff [SYNC_STAGES];
  logic [N_IN-1:0] sync;
  logic [N_IN-1:0] prev;
  logic [N_IN-1:0] rise_en_q, fall_en_q, status_q;
  logic [N_IN-1:0] rise_en_next, fall_en_next, status_next;
  logic [N_IN-1:0] clr, rise, fall;
  logic [N_OUT-1:0] out_next;
  logic [N_OUT-1:0] wdat_out;
  logic [N_IN-1:0]  wdat_in;
  logic [31:0]     rd_val;
  logic            unused_ok;

  assign acc       = HSEL & (HTRANS != 2'b00);
  assign wdat_out  = HWDATA[N_OUT-1:0];
  assign wdat_in   = HWDATA[N_IN-1:0];
  assign unused_ok = ^{HADDR[1:0], HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      addr_q <= 3'd0;
    end else begin
      wr_q   <= acc & HWRITE;
      addr_q <= HADDR[4:2];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev <= '0;
    end else begin
      sync_ff[0] <= GPIO_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev <= sync;
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];
  assign rise = sync & ~prev & rise_en_q;
  assign fall = ~sync & prev & fall_en_q;

  always_comb begin
    out_next     = GPIO_OUT;
    rise_en_next = rise_en_q;
    fall_en_next = fall_en_q;
    clr          = '0;
    if (wr_q) begin
      case (addr_q)
        A_OUT:     out_next     = wdat_out;
        A_OUT_SET: out_next     = GPIO_OUT | wdat_out;
        A_OUT_CLR: out_next     = GPIO_OUT & ~wdat_out;
        A_OUT_TGL: out_next     = GPIO_OUT ^ wdat_out;
        A_RISE_EN: rise_en_next = wdat_in;
        A_FALL_EN: fall_en_next = wdat_in;
        A_STATUS:  clr          = wdat_in;
        default:   ;
      endcase
    end
    // A fresh edge beats a same-cycle clear so no event is lost.
    status_next = (status_q & ~clr) | rise | fall;
  end

  // Read mux uses next-state values so a read right behind a write sees the committed result.
  always_comb begin
    rd_val = '0;
    case (HADDR[4:2])
      A_OUT:     rd_val[N_OUT-1:0] = out_next;
      A_IN:      rd_val[N_IN-1:0]  = sync;
      A_RISE_EN: rd_val[N_IN-1:0]  = rise_en_next;
      A_FALL_EN: rd_val[N_IN-1:0]  = fall_en_next;
      A_STATUS:  rd_val[N_IN-1:0]  = (wr_q && addr_q == A_STATUS) ? status_next : status_q;
      default:   ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      GPIO_OUT  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      IRQ       <= 1'b0;
      HRDATA    <= '0;
    end else begin
      GPIO_OUT  <= out_next;
      rise_en_q <= rise_en_next;
      fall_en_q <= fall_en_next;
      status_q  <= status_next;
      IRQ       <= |status_next;
      HRDATA    <= (acc && !HWRITE) ? rd_val : 32'h0;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_gpio_irq.sv
// Self-checking bench for mfp_ahb_gpio_irq: vector table for register behaviour, directed sequences for edges, W1C and reset.
module tb_mfp_ahb_gpio_irq;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [4:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [21:0] GPIO_IN;
  logic [15:0] GPIO_OUT;
  logic        IRQ;

  mfp_ahb_gpio_irq #(.N_IN(22), .N_OUT(16), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSEL(HSEL), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [15:0] exp_out;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  logic [31:0] pend_wdata;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive an address phase plus the pending write data, step an edge, check read data.
  task automatic cycle(input bit v, input bit w, input logic [2:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
    logic [31:0] e;
    HWDATA = pend_wdata;
    HSEL   = v;
    HTRANS = v ? 2'b10 : 2'b00;
    HWRITE = w;
    HADDR  = {a, 2'b00};
    if (v && !w) sb.push_back(exp);
    pend_wdata = (v && w) ? d : 32'h0;
    @(posedge HCLK);
    #1;
    if (v && !w) begin
      e = sb.pop_front();
      chk($sformatf("rd_a%0d", a), HRDATA, e);
    end else begin
      chk("rd_idle", HRDATA, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic add(input bit wr, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic [15:0] exp_out);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.exp_rd = exp_rd; v.exp_out = exp_out;
    vecs.push_back(v);
  endtask

  initial begin
    HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSEL = 1'b0;
    HWDATA = '0; GPIO_IN = '0; pend_wdata = '0;

    // write/read vector table: GPIO_OUT column is the value after each edge
    add(1, 3'd0, 32'h0000_0F0F, 0, 16'h0000);
    add(1, 3'd1, 32'h0000_00F0, 0, 16'h0F0F);
    add(1, 3'd2, 32'h0000_000F, 0, 16'h0FFF);
    add(1, 3'd3, 32'h0000_FFFF, 0, 16'h0FF0);
    add(0, 3'd0, 0, 32'h0000_F00F, 16'hF00F);
    add(0, 3'd1, 0, 32'h0,         16'hF00F);
    add(1, 3'd4, 32'hFFFF_FFFF, 0, 16'hF00F);
    add(0, 3'd4, 0, 32'h0,         16'hF00F);
    add(1, 3'd0, 32'hFFFF_FFFF, 0, 16'hF00F);
    add(0, 3'd0, 0, 32'h0000_FFFF, 16'hFFFF);
    add(0, 3'd2, 0, 32'h0,         16'hFFFF);
    add(0, 3'd3, 0, 32'h0,         16'hFFFF);
    add(1, 3'd5, 32'hFFFF_FFFF, 0, 16'hFFFF);
    add(0, 3'd5, 0, 32'h003F_FFFF, 16'hFFFF);
    add(1, 3'd6, 32'h0000_0001, 0, 16'hFFFF);
    add(0, 3'd6, 0, 32'h0000_0001, 16'hFFFF);
    add(1, 3'd5, 32'h0000_0008, 0, 16'hFFFF);
    add(1, 3'd0, 32'h0000_0000, 0, 16'hFFFF);
    add(0, 3'd5, 0, 32'h0000_0008, 16'h0000);
    add(0, 3'd7, 0, 32'h0,         16'h0000);

    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_gpio_out", {16'h0, GPIO_OUT}, 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    idle(1);

    for (int i = 0; i < 8; i++) cycle(1'b0 == 1'b0, 1'b0, 3'(i), 32'h0, 32'h0);
    chk("post_rst_irq", {31'h0, IRQ}, 32'h0);

    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rd);
      chk($sformatf("vec%0d_gpio_out", i), {16'h0, GPIO_OUT}, {16'h0, vecs[i].exp_out});
    end
    idle(1);

    // rising edge on bit 3, held for 5 edges
    GPIO_IN[3] = 1'b1;
    idle(2);
    chk("rise_irq_early", {31'h0, IRQ}, 32'h0);
    cycle(1, 0, 3'd4, 0, 32'h0000_0008);
    chk("rise_irq", {31'h0, IRQ}, 32'h1);
    cycle(1, 0, 3'd7, 0, 32'h0000_0008);
    idle(1);
    GPIO_IN[3] = 1'b0;
    idle(4);
    chk("fall_no_flag_irq", {31'h0, IRQ}, 32'h1);
    cycle(1, 0, 3'd7, 0, 32'h0000_0008);
    cycle(1, 1, 3'd7, 32'h0000_0008, 0);
    idle(1);
    chk("w1c_irq", {31'h0, IRQ}, 32'h0);
    cycle(1, 0, 3'd7, 0, 32'h0);

    // falling edge on bit 0, then clear it
    GPIO_IN[0] = 1'b1;
    idle(4);
    chk("rise0_not_enabled", {31'h0, IRQ}, 32'h0);
    GPIO_IN[0] = 1'b0;
    idle(3);
    chk("fall0_irq", {31'h0, IRQ}, 32'h1);
    cycle(1, 1, 3'd7, 32'h1, 0);
    idle(1);
    chk("fall0_w1c_irq", {31'h0, IRQ}, 32'h0);

    // new fall edge lands on the W1C commit edge: the flag must survive
    GPIO_IN[0] = 1'b1;
    idle(4);
    GPIO_IN[0] = 1'b0;
    idle(1);
    cycle(1, 1, 3'd7, 32'h1, 0);
    idle(1);
    chk("set_wins_irq", {31'h0, IRQ}, 32'h1);
    cycle(1, 0, 3'd7, 0, 32'h0000_0001);

    // reset during a write data phase
    cycle(1, 1, 3'd0, 32'h0000_5A5A, 0);
    idle(1);
    chk("pre_rst_gpio_out", {16'h0, GPIO_OUT}, 32'h0000_5A5A);
    cycle(1, 1, 3'd0, 32'h0000_1234, 0);
    HWDATA = pend_wdata;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    pend_wdata = 32'h0;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_gpio_out", {16'h0, GPIO_OUT}, 32'h0);
    chk("mid_rst_irq", {31'h0, IRQ}, 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    chk("rst_hold_gpio_out", {16'h0, GPIO_OUT}, 32'h0);
    cycle(1, 0, 3'd7, 0, 32'h0);
    cycle(1, 0, 3'd0, 0, 32'h0);
    chk("after_rst_irq", {31'h0, IRQ}, 32'h0);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
